// File: rtl/spififo_pkg.sv
// Shared types and sizing helpers for the SPI FIFO peripheral.
// Used by the top module and its FIFO sub-module.
package spififo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    // Width of a level counter that must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spififo_sync_fifo.sv
// Single-clock FIFO with registered level; data at the head is read combinationally.
// A push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
module spififo_sync_fifo
    import spififo_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WORD_W-1:0]         push_data,
    input  logic                      pop,
    output logic [WORD_W-1:0]         pop_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spififo_peripheral.sv
// SPI peripheral (mode 0/1, oversampled in refclk) with RX/TX FIFOs, hold, threshold irq and sticky errors.
// Pin-to-FSM latency 3 refclk; TX backpressure via tx_ready, RX words dropped (overflow) when RX is full.
module spififo_peripheral
    import spififo_pkg::*;
#(
    parameter int                WORD_W    = 16,
    parameter int                DEPTH     = 16,
    parameter int                CPHA      = 0,
    parameter logic [WORD_W-1:0] IDLE_WORD = 16'hDDDD
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      spi_sclk,
    input  logic                      spi_csn,
    input  logic                      spi_copi,
    output logic                      spi_cipo,
    output logic                      spi_hold,
    output logic                      irq,
    input  logic [WORD_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [WORD_W-1:0]         rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [level_w(DEPTH)-1:0] rx_level,
    output logic [level_w(DEPTH)-1:0] tx_level,
    input  logic [level_w(DEPTH)-1:0] irq_thresh,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_err
);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

    // Synchronisers track the pins through reset so no false csn edge appears afterwards.
    logic [1:0] sclk_sync, csn_sync, copi_sync;
    logic       sclk_d, csn_d;

    always_ff @(posedge refclk) begin
        sclk_sync <= {sclk_sync[0], spi_sclk};
        csn_sync  <= {csn_sync[0], spi_csn};
        copi_sync <= {copi_sync[0], spi_copi};
        sclk_d    <= sclk_sync[1];
        csn_d     <= csn_sync[1];
    end

    logic sclk_rise, sclk_fall, csn_fall, csn_rise, shift_edge, sample_edge;
    assign sclk_rise   = sclk_sync[1] & ~sclk_d;
    assign sclk_fall   = ~sclk_sync[1] & sclk_d;
    assign csn_rise    = csn_sync[1] & ~csn_d;
    assign csn_fall    = ~csn_sync[1] & csn_d;
    assign shift_edge  = (CPHA == 0) ? sclk_fall : sclk_rise;
    assign sample_edge = (CPHA == 0) ? sclk_rise : sclk_fall;

    logic [WORD_W-1:0] tx_head, load_word, shreg, rx_word;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_pop, rx_push, rx_drop, do_load, do_shift, do_sample;
    logic [CW-1:0]     bit_cnt;
    state_t            state_q, state_d;

    assign tx_ready  = ~tx_full;
    assign rx_valid  = ~rx_empty;
    assign load_word = tx_empty ? IDLE_WORD : tx_head;
    assign rx_word   = {shreg[WORD_W-2:0], copi_sync[1]};
    assign rx_drop   = rx_push & rx_full & ~rx_ready;

    always_comb begin
        state_d   = state_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        if (csn_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (csn_fall) state_d = LOAD;
                LOAD: begin
                    do_load = 1'b1;
                    tx_pop  = ~tx_empty;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    do_shift  = shift_edge;
                    do_sample = sample_edge;
                    if (sample_edge && bit_cnt == LAST_BIT) begin
                        rx_push = 1'b1;
                        state_d = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            spi_cipo  <= 1'b0;
            spi_hold  <= 1'b1;
            irq       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_load) begin
                shreg   <= load_word;
                bit_cnt <= '0;
                if (CPHA == 0) spi_cipo <= load_word[WORD_W-1];
            end
            if (do_shift) spi_cipo <= shreg[WORD_W-1];
            if (do_sample) begin
                shreg   <= rx_word;
                bit_cnt <= bit_cnt + 1'b1;
            end
            spi_hold  <= (tx_level == '0);
            irq       <= (irq_thresh != '0) && (rx_level >= irq_thresh);
            overflow  <= (overflow & ~clear_err) | rx_drop;
            underflow <= (underflow & ~clear_err) | (do_load & tx_empty);
        end
    end

    spififo_sync_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (refclk),
        .rst       (rst),
        .push      (tx_valid & tx_ready),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spififo_sync_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (refclk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule

// File: tb/tb_spififo_peripheral.sv
// Scoreboard bench: a mode-0 instance and a mode-1 instance driven by a bit-banged SPI controller.
module tb_spififo_peripheral;
    localparam int LW = 5;

    logic refclk = 1'b0;
    logic rst = 1'b1;
    always #5 refclk = ~refclk;

    logic        sclk = 1'b0, copi = 1'b0, csn0 = 1'b1, csn1 = 1'b1;
    logic [15:0] tx_data = '0;
    logic [LW-1:0] irq_thresh = '0;
    logic        clear_err = 1'b0;

    logic        cipo0, hold0, irq0, tx_valid0 = 1'b0, tx_ready0, rx_valid0, rx_ready0 = 1'b0, ovf0, unf0;
    logic [15:0] rx_data0;
    logic [LW-1:0] rx_level0, tx_level0;
    logic        cipo1, hold1, irq1, tx_valid1 = 1'b0, tx_ready1, rx_valid1, rx_ready1 = 1'b0, ovf1, unf1;
    logic [15:0] rx_data1;
    logic [LW-1:0] rx_level1, tx_level1;

    spififo_peripheral #(.WORD_W(16), .DEPTH(16), .CPHA(0), .IDLE_WORD(16'hDDDD)) dut0 (
        .refclk(refclk), .rst(rst), .spi_sclk(sclk), .spi_csn(csn0), .spi_copi(copi),
        .spi_cipo(cipo0), .spi_hold(hold0), .irq(irq0), .tx_data(tx_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_level(rx_level0), .tx_level(tx_level0), .irq_thresh(irq_thresh), .overflow(ovf0),
        .underflow(unf0), .clear_err(clear_err));

    spififo_peripheral #(.WORD_W(16), .DEPTH(16), .CPHA(1), .IDLE_WORD(16'hDDDD)) dut1 (
        .refclk(refclk), .rst(rst), .spi_sclk(sclk), .spi_csn(csn1), .spi_copi(copi),
        .spi_cipo(cipo1), .spi_hold(hold1), .irq(irq1), .tx_data(tx_data), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .rx_level(rx_level1), .tx_level(tx_level1), .irq_thresh(irq_thresh), .overflow(ovf1),
        .underflow(unf1), .clear_err(clear_err));

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] send_q[$], got_q[$], exp_cipo[$], exp_rx[$];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tick();
    endtask

    task automatic host_push(input int sel, input logic [15:0] w);
        tx_data = w;
        if (sel == 0) tx_valid0 = 1'b1; else tx_valid1 = 1'b1;
        tick();
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    task automatic host_pop(input int sel, output logic v, output logic [15:0] d);
        v = (sel == 0) ? rx_valid0 : rx_valid1;
        d = (sel == 0) ? rx_data0 : rx_data1;
        if (sel == 0) rx_ready0 = 1'b1; else rx_ready1 = 1'b1;
        tick();
        rx_ready0 = 1'b0;
        rx_ready1 = 1'b0;
    endtask

    // Controller side: half period of 8 refclk cycles; cipo is read just before the sampling edge.
    task automatic spi_bit(input int sel, input logic b, output logic c);
        if (sel == 0) begin
            copi = b;
            repeat (8) tick();
            c = cipo0;
            sclk = 1'b1;
            repeat (8) tick();
            sclk = 1'b0;
        end else begin
            sclk = 1'b1;
            copi = b;
            repeat (8) tick();
            c = cipo1;
            sclk = 1'b0;
            repeat (8) tick();
        end
    endtask

    task automatic set_csn(input int sel, input logic v);
        if (sel == 0) csn0 = v; else csn1 = v;
        repeat (8) tick();
    endtask

    task automatic spi_frame(input int sel);
        logic [15:0] r;
        logic c;
        got_q.delete();
        set_csn(sel, 1'b0);
        foreach (send_q[k]) begin
            for (int i = 15; i >= 0; i--) begin
                spi_bit(sel, send_q[k][i], c);
                r[i] = c;
            end
            got_q.push_back(r);
        end
        set_csn(sel, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({cipo0, hold0, irq0, tx_ready0, rx_valid0, rx_level0, tx_level0, ovf0, unf0} !==
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mode0: got cipo%b hold%b irq%b rdy%b vld%b rxl%0d txl%0d ovf%b unf%b, want 0 1 0 1 0 0 0 0 0",
                     cipo0, hold0, irq0, tx_ready0, rx_valid0, rx_level0, tx_level0, ovf0, unf0);
        end
        vectors++;
        if ({cipo1, hold1, irq1, tx_ready1, rx_valid1, rx_level1, tx_level1, ovf1, unf1} !==
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mode1: got cipo%b hold%b irq%b rdy%b vld%b rxl%0d txl%0d ovf%b unf%b, want 0 1 0 1 0 0 0 0 0",
                     cipo1, hold1, irq1, tx_ready1, rx_valid1, rx_level1, tx_level1, ovf1, unf1);
        end
    endtask

    task automatic test_stream(input int sel);
        logic v;
        logic [15:0] d, e;
        exp_cipo.delete();
        exp_rx.delete();
        exp_cipo.push_back(16'hA503);
        exp_cipo.push_back(16'h1234);
        host_push(sel, 16'hA503);
        host_push(sel, 16'h1234);
        tick();
        vectors++;
        if (((sel == 0) ? {hold0, tx_level0} : {hold1, tx_level1}) !== {1'b0, 5'd2}) begin
            miscompares++;
            $display("FAIL stream%0d_hold_level: got %b want hold 0 level 2", sel,
                     (sel == 0) ? {hold0, tx_level0} : {hold1, tx_level1});
        end
        send_q = '{16'hBEEF, 16'hCAFE};
        exp_rx.push_back(16'hBEEF);
        exp_rx.push_back(16'hCAFE);
        spi_frame(sel);
        foreach (got_q[k]) begin
            e = exp_cipo.pop_front();
            vectors++;
            if (got_q[k] !== e) begin
                miscompares++;
                $display("FAIL stream%0d_cipo[%0d]: got %h want %h", sel, k, got_q[k], e);
            end
        end
        vectors++;
        if (((sel == 0) ? hold0 : hold1) !== 1'b1) begin
            miscompares++;
            $display("FAIL stream%0d_hold_after: got 0 want 1", sel);
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            host_pop(sel, v, d);
            vectors++;
            if ({v, d} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL stream%0d_rx: got vld %b data %h want vld 1 data %h", sel, v, d, e);
            end
        end
        vectors++;
        if (((sel == 0) ? rx_valid0 : rx_valid1) !== 1'b0) begin
            miscompares++;
            $display("FAIL stream%0d_rx_empty: got rx_valid 1 want 0", sel);
        end
        pulse_clear();
    endtask

    task automatic test_underflow();
        logic v;
        logic [15:0] d;
        vectors++;
        if (unf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_pre: got %b want 0", unf0);
        end
        send_q = '{16'h0F0F};
        spi_frame(0);
        vectors++;
        if (got_q[0] !== 16'hDDDD) begin
            miscompares++;
            $display("FAIL underflow_cipo: got %h want dddd", got_q[0]);
        end
        repeat (5) tick();
        vectors++;
        if (unf0 !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_sticky: got %b want 1", unf0);
        end
        host_pop(0, v, d);
        vectors++;
        if ({v, d} !== {1'b1, 16'h0F0F}) begin
            miscompares++;
            $display("FAIL underflow_rx: got vld %b data %h want 1 0f0f", v, d);
        end
        pulse_clear();
        vectors++;
        if (unf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_clear: got %b want 0", unf0);
        end
    endtask

    task automatic test_overflow();
        logic v;
        logic [15:0] d, e;
        send_q.delete();
        exp_rx.delete();
        for (int k = 0; k < 17; k++) begin
            send_q.push_back(16'h5A00 + 16'(k * 16'h0131));
            if (k < 16) exp_rx.push_back(16'h5A00 + 16'(k * 16'h0131));
        end
        spi_frame(0);
        vectors++;
        if ({rx_level0, ovf0} !== {5'd16, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_state: got level %0d ovf %b want 16 1", rx_level0, ovf0);
        end
        for (int k = 0; k < 16; k++) begin
            e = exp_rx.pop_front();
            host_pop(0, v, d);
            vectors++;
            if ({v, d} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL overflow_rx[%0d]: got vld %b data %h want 1 %h", k, v, d, e);
            end
        end
        vectors++;
        if (rx_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_lost_word: got rx_valid 1 want 0");
        end
        pulse_clear();
    endtask

    task automatic test_irq();
        logic v, seen;
        logic [15:0] d, e;
        irq_thresh = 5'd3;
        send_q = '{16'h1111, 16'h2222, 16'h3333};
        exp_rx.delete();
        foreach (send_q[k]) exp_rx.push_back(send_q[k]);
        seen = 1'b0;
        fork
            spi_frame(0);
            begin
                for (int c = 0; c < 3000 && !seen; c++) begin
                    @(negedge refclk);
                    if (rx_level0 == 5'd3) seen = 1'b1;
                end
                vectors++;
                if (!seen) begin
                    miscompares++;
                    $display("FAIL irq_level_timeout: rx_level never reached 3");
                end else begin
                    if (irq0 !== 1'b0) begin
                        miscompares++;
                        $display("FAIL irq_early: got 1 want 0 on the level-3 cycle");
                    end
                    @(negedge refclk);
                    vectors++;
                    if (irq0 !== 1'b1) begin
                        miscompares++;
                        $display("FAIL irq_rise: got 0 want 1 one cycle after level 3");
                    end
                end
            end
        join
        e = exp_rx.pop_front();
        host_pop(0, v, d);
        vectors++;
        if ({v, d, irq0} !== {1'b1, e, 1'b1}) begin
            miscompares++;
            $display("FAIL irq_pop1: got vld %b data %h irq %b want 1 %h 1", v, d, irq0, e);
        end
        tick();
        vectors++;
        if (irq0 !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_fall: got 1 want 0 after level dropped to 2");
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            host_pop(0, v, d);
            vectors++;
            if ({v, d} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL irq_rx: got vld %b data %h want 1 %h", v, d, e);
            end
        end
        irq_thresh = '0;
        pulse_clear();
    endtask

    task automatic test_partial_frame();
        logic v, c;
        logic [15:0] d;
        set_csn(0, 1'b0);
        for (int i = 0; i < 7; i++) spi_bit(0, 1'b1, c);
        set_csn(0, 1'b1);
        vectors++;
        if (rx_level0 !== 5'd0) begin
            miscompares++;
            $display("FAIL partial_no_push: got rx_level %0d want 0", rx_level0);
        end
        send_q = '{16'h9A5C};
        spi_frame(0);
        host_pop(0, v, d);
        vectors++;
        if ({v, d} !== {1'b1, 16'h9A5C}) begin
            miscompares++;
            $display("FAIL partial_next_word: got vld %b data %h want 1 9a5c", v, d);
        end
        pulse_clear();
    endtask

    task automatic test_tx_full();
        for (int k = 0; k < 16; k++) host_push(0, 16'h3000 + 16'(k));
        vectors++;
        if ({tx_level0, tx_ready0} !== {5'd16, 1'b0}) begin
            miscompares++;
            $display("FAIL tx_full: got level %0d ready %b want 16 0", tx_level0, tx_ready0);
        end
        host_push(0, 16'hFFFF);
        vectors++;
        if (tx_level0 !== 5'd16) begin
            miscompares++;
            $display("FAIL tx_full_reject: got level %0d want 16", tx_level0);
        end
    endtask

    task automatic test_reset_midframe();
        logic c;
        set_csn(0, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, c);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({cipo0, hold0, irq0, tx_ready0, rx_valid0, rx_level0, tx_level0, ovf0, unf0} !==
            {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midframe_reset: got cipo%b hold%b irq%b rdy%b vld%b rxl%0d txl%0d ovf%b unf%b",
                     cipo0, hold0, irq0, tx_ready0, rx_valid0, rx_level0, tx_level0, ovf0, unf0);
        end
        set_csn(0, 1'b1);
        vectors++;
        if ({unf0, rx_level0} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL midframe_resync: got unf %b rx_level %0d want 0 0", unf0, rx_level0);
        end
    endtask

    initial begin
        test_reset();
        test_stream(0);
        test_underflow();
        test_overflow();
        test_irq();
        test_partial_frame();
        test_tx_full();
        test_reset_midframe();
        test_stream(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
